// File: rtl/mem_port_sequencer.sv
// Shares one req/ack memory bus between the instruction-fetch port and the load/store port.
// Optional MEM_TIMEOUT_EN: aborts a bus transaction that stays unacknowledged for TIMEOUT_CYCLES.
module mem_port_sequencer #(
  parameter int                   WORD_SIZE      = 32,
  parameter int                   TIMEOUT_CYCLES = 255,
  parameter logic [WORD_SIZE-1:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_req,
  input  logic [WORD_SIZE-1:0] fetch_addr,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [WORD_SIZE-1:0] data_addr,
  input  logic [WORD_SIZE-1:0] data_wdata,
  output logic [WORD_SIZE-1:0] instr_out,
  output logic                 fetch_valid,
  output logic [WORD_SIZE-1:0] data_rdata,
  output logic                 data_done,
  output logic                 stall,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [WORD_SIZE-1:0] bus_addr,
  output logic [WORD_SIZE-1:0] bus_wdata,
  input  logic                 bus_ack,
  input  logic [WORD_SIZE-1:0] bus_rdata,
  output logic                 bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic                   bus_we_reg, bus_we_next;
  logic [WORD_SIZE-1:0]   bus_addr_reg, bus_addr_next;
  logic [WORD_SIZE-1:0]   bus_wdata_reg, bus_wdata_next;
  logic [WORD_SIZE-1:0]   instr_reg, instr_next;
  logic [WORD_SIZE-1:0]   rdata_reg, rdata_next;
  logic                   fetch_valid_reg, fetch_valid_next;
  logic                   data_done_reg, data_done_next;
  logic                   bus_err_reg, bus_err_next;

  logic fetch_elig;
  logic data_elig;
  logic busy;
  logic ack_hit;
  logic timeout_hit;

  // A request whose done pulse is showing this cycle was just served; don't re-issue it.
  assign fetch_elig = fetch_req & ~fetch_valid_reg;
  assign data_elig  = data_req & ~data_done_reg;
  assign busy       = (state_reg != IDLE);
  assign ack_hit    = busy & bus_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

  // An ack arriving on the final wait cycle takes precedence over the abort.
  assign timeout_hit = busy & ~bus_ack & (wait_cnt_reg == LAST_WAIT);

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!busy) begin
      wait_cnt_next = '0;
    end else if (!bus_ack) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, ERR_DATA};
  assign timeout_hit        = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      bus_we_reg      <= 1'b0;
      bus_addr_reg    <= '0;
      bus_wdata_reg   <= '0;
      instr_reg       <= '0;
      rdata_reg       <= '0;
      fetch_valid_reg <= 1'b0;
      data_done_reg   <= 1'b0;
      bus_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bus_we_reg      <= bus_we_next;
      bus_addr_reg    <= bus_addr_next;
      bus_wdata_reg   <= bus_wdata_next;
      instr_reg       <= instr_next;
      rdata_reg       <= rdata_next;
      fetch_valid_reg <= fetch_valid_next;
      data_done_reg   <= data_done_next;
      bus_err_reg     <= bus_err_next;
    end
  end

  // Next-state logic: data has strict priority over fetch.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (data_elig) begin
          state_next = DATA;
        end else if (fetch_elig) begin
          state_next = FETCH;
        end
      end
      FETCH, DATA: begin
        if (ack_hit || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath next values: latch the request on issue, capture the response on completion.
  always_comb begin
    bus_we_next      = bus_we_reg;
    bus_addr_next    = bus_addr_reg;
    bus_wdata_next   = bus_wdata_reg;
    instr_next       = instr_reg;
    rdata_next       = rdata_reg;
    fetch_valid_next = 1'b0;
    data_done_next   = 1'b0;
    bus_err_next     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (data_elig) begin
          bus_addr_next  = data_addr;
          bus_we_next    = data_we;
          bus_wdata_next = data_wdata;
        end else if (fetch_elig) begin
          bus_addr_next = fetch_addr;
          bus_we_next   = 1'b0;
        end
      end
      FETCH: begin
        if (ack_hit) begin
          instr_next       = bus_rdata;
          fetch_valid_next = 1'b1;
        end else if (timeout_hit) begin
          instr_next       = ERR_DATA;
          fetch_valid_next = 1'b1;
          bus_err_next     = 1'b1;
        end
      end
      DATA: begin
        if (ack_hit) begin
          if (!bus_we_reg) begin
            rdata_next = bus_rdata;
          end
          data_done_next = 1'b1;
          bus_we_next    = 1'b0;
        end else if (timeout_hit) begin
          if (!bus_we_reg) begin
            rdata_next = ERR_DATA;
          end
          data_done_next = 1'b1;
          bus_we_next    = 1'b0;
          bus_err_next   = 1'b1;
        end
      end
      default: begin
        bus_we_next = 1'b0;
      end
    endcase
  end

  // Outputs; bus_req follows the state so reset drops it immediately.
  always_comb begin
    bus_req     = busy;
    stall       = busy | data_elig | fetch_elig;
    bus_we      = bus_we_reg;
    bus_addr    = bus_addr_reg;
    bus_wdata   = bus_wdata_reg;
    instr_out   = instr_reg;
    data_rdata  = rdata_reg;
    fetch_valid = fetch_valid_reg;
    data_done   = data_done_reg;
    bus_err     = bus_err_reg;
  end

endmodule
